// File: rtl/arcade_rom_loader.sv
// Purpose: route the data_io ROM download stream into per-region write strobes and sequence the core reset.
// Latency: one cycle from ioctl_wr to rgn_wr/rgn_addr/rgn_data.
// Backpressure: none; data_io cannot be stalled, so every accepted byte is forwarded or flagged.
//
// Ports:
//   clk_sys, reset           system clock, synchronous active-high reset
//   ioctl_downl/index/wr     data_io download control (wr is a 1-cycle byte strobe)
//   ioctl_addr/dout          byte address and data of the download stream
//   rgn_wr                   one-hot write strobe, one bit per region
//   rgn_addr/rgn_data        region-local address and data accompanying rgn_wr
//   core_reset               reset to the core: held during the download and RESET_HOLD+1 cycles after it
//   dl_done/dl_error         sticky status of the last ROM download
//   byte_count               bytes received in the current/last ROM download (saturating)
module arcade_rom_loader #(
    parameter int                     REGIONS      = 4,
    parameter int                     AW           = 16,
    parameter logic [7:0]             ROM_INDEX    = 8'd0,
    parameter logic [REGIONS*25-1:0]  REGION_BASE  = '0,
    parameter logic [REGIONS*25-1:0]  REGION_SIZE  = '0,
    parameter logic [24:0]            EXPECT_BYTES = 25'd0,
    parameter logic [15:0]            RESET_HOLD   = 16'd255
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               ioctl_downl,
    input  logic [7:0]         ioctl_index,
    input  logic               ioctl_wr,
    input  logic [24:0]        ioctl_addr,
    input  logic [7:0]         ioctl_dout,
    output logic [REGIONS-1:0] rgn_wr,
    output logic [AW-1:0]      rgn_addr,
    output logic [7:0]         rgn_data,
    output logic               core_reset,
    output logic               dl_done,
    output logic               dl_error,
    output logic [24:0]        byte_count
);

    localparam logic [1:0] ST_HOLD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

    localparam logic [24:0] COUNT_MAX = 25'h1FF_FFFF;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         state_q,      state_d;
    logic [15:0]        hold_cnt_q,   hold_cnt_d;
    logic               rom_dl_q;
    logic [REGIONS-1:0] rgn_wr_q,     rgn_wr_d;
    logic [AW-1:0]      rgn_addr_q,   rgn_addr_d;
    logic [7:0]         rgn_data_q,   rgn_data_d;
    logic               dl_done_q,    dl_done_d;
    logic               dl_error_q,   dl_error_d;
    logic               done_pend_q,  done_pend_d;
    logic [24:0]        byte_count_q, byte_count_d;

    // ------------------------------------------------------------------
    // Download qualification
    // ------------------------------------------------------------------
    logic rom_dl;
    logic rom_rise;
    logic load_exit;
    logic accept;
    logic len_bad;

    assign rom_dl    = ioctl_downl && (ioctl_index == ROM_INDEX);
    assign rom_rise  = rom_dl && !rom_dl_q;
    assign load_exit = (state_q == ST_LOAD) && !rom_dl;
    // A byte that arrives with the rising edge of rom_dl is already part of the
    // download; one that arrives as rom_dl drops is not (rom_dl gates it out).
    assign accept    = ioctl_wr && rom_dl && ((state_q == ST_LOAD) || rom_rise);
    assign len_bad   = (EXPECT_BYTES != 25'd0) && (byte_count_q != EXPECT_BYTES);

    // ------------------------------------------------------------------
    // Region decode. Bounds are compared in 26 bits so BASE+SIZE cannot wrap.
    // ------------------------------------------------------------------
    logic [25:0]        addr26;
    logic [REGIONS-1:0] in_rgn;
    logic [25:0]        rgn_off [REGIONS];
    logic [REGIONS-1:0] hit_vec;
    logic [25:0]        hit_off;
    logic               hit_any;

    assign addr26 = {1'b0, ioctl_addr};

    for (genvar g = 0; g < REGIONS; g++) begin : g_rgn
        localparam logic [25:0] RB = {1'b0, REGION_BASE[25*g +: 25]};
        localparam logic [25:0] RS = {1'b0, REGION_SIZE[25*g +: 25]};
        assign in_rgn[g]  = (RS != 26'd0) && (addr26 >= RB) && (addr26 < (RB + RS));
        assign rgn_off[g] = addr26 - RB;
    end

    // Walk from the top down so the lowest matching region is the last one
    // written; overlapping regions therefore still give a one-hot strobe.
    always_comb begin
        hit_vec = '0;
        hit_off = '0;
        for (int i = REGIONS - 1; i >= 0; i--) begin
            if (in_rgn[i]) begin
                hit_vec    = '0;
                hit_vec[i] = 1'b1;
                hit_off    = rgn_off[i];
            end
        end
    end

    assign hit_any = |in_rgn;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        rgn_wr_d     = '0;
        rgn_addr_d   = rgn_addr_q;
        rgn_data_d   = rgn_data_q;
        dl_done_d    = dl_done_q;
        dl_error_d   = dl_error_q;
        done_pend_d  = done_pend_q;
        byte_count_d = byte_count_q;

        if (rom_rise) begin
            // New ROM download: start from clean status, counting a byte that
            // may accompany the rising edge.
            state_d      = ST_LOAD;
            byte_count_d = accept ? 25'd1 : 25'd0;
            dl_done_d    = 1'b0;
            dl_error_d   = accept && !hit_any;
            done_pend_d  = 1'b0;
        end else if (load_exit) begin
            state_d     = ST_HOLD;
            hold_cnt_d  = RESET_HOLD;
            dl_error_d  = dl_error_q || len_bad;
            // dl_done is derived from the final error flag one cycle later.
            done_pend_d = 1'b1;
        end else begin
            if (state_q == ST_HOLD) begin
                if (hold_cnt_q == 16'd0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - 16'd1;
                end
            end
            if (accept) begin
                if (byte_count_q != COUNT_MAX) begin
                    byte_count_d = byte_count_q + 25'd1;
                end
                if (!hit_any) begin
                    dl_error_d = 1'b1;
                end
            end
            if (done_pend_q) begin
                dl_done_d   = !dl_error_q;
                done_pend_d = 1'b0;
            end
        end

        if (accept && hit_any) begin
            rgn_wr_d   = hit_vec;
            rgn_addr_d = hit_off[AW-1:0];
            rgn_data_d = ioctl_dout;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= ST_HOLD;
            hold_cnt_q   <= RESET_HOLD;
            rom_dl_q     <= 1'b0;
            rgn_wr_q     <= '0;
            rgn_addr_q   <= '0;
            rgn_data_q   <= '0;
            dl_done_q    <= 1'b0;
            dl_error_q   <= 1'b0;
            done_pend_q  <= 1'b0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            rom_dl_q     <= rom_dl;
            rgn_wr_q     <= rgn_wr_d;
            rgn_addr_q   <= rgn_addr_d;
            rgn_data_q   <= rgn_data_d;
            dl_done_q    <= dl_done_d;
            dl_error_q   <= dl_error_d;
            done_pend_q  <= done_pend_d;
            byte_count_q <= byte_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rgn_wr     = rgn_wr_q;
    assign rgn_addr   = rgn_addr_q;
    assign rgn_data   = rgn_data_q;
    assign core_reset = (state_q != ST_RUN);
    assign dl_done    = dl_done_q;
    assign dl_error   = dl_error_q;
    assign byte_count = byte_count_q;

endmodule
